mc_control: RTL and testbench

Main control unit for the multicycle processor. A Moore state machine decodes the instruction-register opcode/funct fields. Each cycle it drives the datapath enables, the mux selects, and the ALU's `AluSrcA`, `AluSrcB` and `controlline` inputs, which sit directly downstream. It sequences fetch, decode, execute, memory and write-back over 3–5 cycles per instruction.

---
 rtl/mc_pkg.sv | 51 +++++
 rtl/mc_control_alu_decoder.sv | 25 ++
 rtl/mc_control.sv | 153 +++++++++++++++
 tb/tb_mc_control.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle control unit and its ALU decoder
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// alu_decoder: maps the control unit's aluop and the funct field to an ALU operation
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] controlline
);

    // Unknown funct codes and the unused aluop 11 fall back to add
    always_comb begin
        controlline = ALU_ADD;
        if (aluop == ALUOP_SUB)
            controlline = ALU_SUB;
        else if (aluop == ALUOP_FUNCT)
            case (funct)
                FN_SUB:  controlline = ALU_SUB;
                FN_AND:  controlline = ALU_AND;
                FN_OR:   controlline = ALU_OR;
                FN_SLT:  controlline = ALU_SLT;
                default: controlline = ALU_ADD;
            endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: Moore FSM sequencing fetch/decode/execute/memory/write-back for the multicycle datapath
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic [1:0] PCSource,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] controlline,
    output logic [3:0] state
);

    logic [3:0] state_q, state_d;
    logic       pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;
    logic       alu_en;
    logic [1:0] aluop;
    logic [2:0] dec_ctl;
    logic       unused_zero;

    assign unused_zero = zero;
    assign state       = state_q;

    alu_decoder u_dec (
        .aluop       (aluop),
        .funct       (funct),
        .controlline (dec_ctl)
    );

    // State register; reset always returns to FETCH, abandoning any partial instruction
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    // Next-state sequencing; illegal encodings 12-15 fall through to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            S_MEMADDR: state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_RWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Per-state output decode; everything not named for a state stays 0
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        IorD          = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        PCSource      = PCSRC_ALU;
        AluSrcA       = 1'b0;
        AluSrcB       = SRCB_B;
        alu_en        = 1'b0;
        aluop         = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                pc_write = 1'b1;
                AluSrcB  = SRCB_ONE;
                alu_en   = 1'b1;
            end
            S_DECODE: begin
                AluSrcB = SRCB_IMMSH;
                alu_en  = 1'b1;
            end
            S_MEMADDR, S_ADDIEX: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                alu_en  = 1'b1;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                MemtoReg  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
            end
            S_EXECUTE: begin
                AluSrcA = 1'b1;
                alu_en  = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                reg_write = 1'b1;
                RegDst    = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA       = 1'b1;
                alu_en        = 1'b1;
                aluop         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                PCSource      = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDIWB: reg_write = 1'b1;
            default: ;
        endcase
    end

    // ALU op is only driven in states that use the ALU; elsewhere it reads as 000
    assign controlline = alu_en ? dec_ctl : 3'b000;

    // Reset masks every read/write enable so no side effect happens in a reset cycle
    assign PCWrite     = pc_write & ~reset;
    assign PCWriteCond = pc_write_cond & ~reset;
    assign MemRead     = mem_read & ~reset;
    assign MemWrite    = mem_write & ~reset;
    assign IRWrite     = ir_write & ~reset;
    assign RegWrite    = reg_write & ~reset;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed per-instruction checks of the multicycle control FSM
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, AluSrcA;
    logic [1:0] PCSource, AluSrcB;
    logic [2:0] controlline;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mc_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .PCSource    (PCSource),
        .AluSrcA     (AluSrcA),
        .AluSrcB     (AluSrcB),
        .controlline (controlline),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (state !== 4'd0 || {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite} !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold: state=%0d enables=%b, required state=0 enables=000000", state,
                         {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite});
            end
            checks++;
            if (AluSrcB !== 2'b01 || controlline !== 3'b010 || {AluSrcA, IorD, MemtoReg, RegDst, PCSource} !== 6'b0) begin
                errors++;
                $display("FAIL reset_selects: AluSrcB=%b controlline=%b others=%b, required 01 010 000000",
                         AluSrcB, controlline, {AluSrcA, IorD, MemtoReg, RegDst, PCSource});
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({MemRead, IRWrite, PCWrite} !== 3'b111 || AluSrcB !== 2'b01 || controlline !== 3'b010 || state !== 4'd0) begin
            errors++;
            $display("FAIL fetch_after_reset: MemRead/IRWrite/PCWrite=%b AluSrcB=%b ctl=%b state=%0d, required 111 01 010 0",
                     {MemRead, IRWrite, PCWrite}, AluSrcB, controlline, state);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns[4] = '{6'b100010, 6'b101010, 6'b100101, 6'b111111};
        logic [2:0] ctl[4] = '{3'b110, 3'b111, 3'b001, 3'b010};
        logic [3:0] seq[4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        for (int f = 0; f < 4; f++) begin
            opcode = 6'b000000; funct = fns[f];
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (state !== seq[i]) begin
                    errors++;
                    $display("FAIL rtype_state fn=%b step %0d: state=%0d, required %0d", fns[f], i, state, seq[i]);
                end
                if (i == 2) begin
                    checks++;
                    if (controlline !== ctl[f] || AluSrcA !== 1'b1 || AluSrcB !== 2'b00) begin
                        errors++;
                        $display("FAIL rtype_exec fn=%b: ctl=%b srcA=%b srcB=%b, required %b 1 00",
                                 fns[f], controlline, AluSrcA, AluSrcB, ctl[f]);
                    end
                end
                if (i == 3) begin
                    checks++;
                    if (RegWrite !== 1'b1 || RegDst !== 1'b1 || MemtoReg !== 1'b0) begin
                        errors++;
                        $display("FAIL rtype_wb: RegWrite=%b RegDst=%b MemtoReg=%b, required 1 1 0", RegWrite, RegDst, MemtoReg);
                    end
                end
                tick();
            end
            checks++;
            if (state !== 4'd0) begin
                errors++;
                $display("FAIL rtype_return: state=%0d, required 0", state);
            end
        end
    endtask

    task automatic test_lw_sw();
        logic [3:0] lw_seq[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [3:0] sw_seq[4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== lw_seq[i]) begin
                errors++;
                $display("FAIL lw_state step %0d: state=%0d, required %0d", i, state, lw_seq[i]);
            end
            if (i == 2) begin
                checks++;
                if (AluSrcA !== 1'b1 || AluSrcB !== 2'b10 || controlline !== 3'b010) begin
                    errors++;
                    $display("FAIL lw_addr: srcA=%b srcB=%b ctl=%b, required 1 10 010", AluSrcA, AluSrcB, controlline);
                end
            end
            if (i == 3) begin
                checks++;
                if (IorD !== 1'b1 || MemRead !== 1'b1 || controlline !== 3'b000) begin
                    errors++;
                    $display("FAIL lw_read: IorD=%b MemRead=%b ctl=%b, required 1 1 000", IorD, MemRead, controlline);
                end
            end
            if (i == 4) begin
                checks++;
                if (MemtoReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_wb: MemtoReg=%b RegWrite=%b RegDst=%b, required 1 1 0", MemtoReg, RegWrite, RegDst);
                end
            end
            tick();
        end
        opcode = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== sw_seq[i] || MemWrite !== (i == 3)) begin
                errors++;
                $display("FAIL sw_step %0d: state=%0d MemWrite=%b, required %0d %b", i, state, MemWrite, sw_seq[i], i == 3);
            end
            tick();
        end
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL sw_return: state=%0d, required 0", state);
        end
    endtask

    task automatic test_beq_j();
        opcode = 6'b000100; zero = 1'b1;
        tick();
        checks++;
        if (state !== 4'd1 || AluSrcB !== 2'b11 || controlline !== 3'b010) begin
            errors++;
            $display("FAIL beq_decode: state=%0d srcB=%b ctl=%b, required 1 11 010", state, AluSrcB, controlline);
        end
        tick();
        checks++;
        if (state !== 4'd8 || PCWriteCond !== 1'b1 || PCSource !== 2'b01 || controlline !== 3'b110 || PCWrite !== 1'b0) begin
            errors++;
            $display("FAIL beq_branch: state=%0d PCWriteCond=%b PCSource=%b ctl=%b PCWrite=%b, required 8 1 01 110 0",
                     state, PCWriteCond, PCSource, controlline, PCWrite);
        end
        zero = 1'b0;
        tick();
        opcode = 6'b000010;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL beq_return: state=%0d, required 0", state);
        end
        tick(); tick();
        checks++;
        if (state !== 4'd9 || PCWrite !== 1'b1 || PCSource !== 2'b10 || AluSrcB !== 2'b00) begin
            errors++;
            $display("FAIL j_jump: state=%0d PCWrite=%b PCSource=%b srcB=%b, required 9 1 10 00", state, PCWrite, PCSource, AluSrcB);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL j_return: state=%0d, required 0", state);
        end
    endtask

    task automatic test_addi();
        opcode = 6'b001000;
        tick(); tick();
        checks++;
        if (state !== 4'd10 || AluSrcA !== 1'b1 || AluSrcB !== 2'b10 || controlline !== 3'b010) begin
            errors++;
            $display("FAIL addi_ex: state=%0d srcA=%b srcB=%b ctl=%b, required 10 1 10 010", state, AluSrcA, AluSrcB, controlline);
        end
        tick();
        checks++;
        if (state !== 4'd11 || RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0) begin
            errors++;
            $display("FAIL addi_wb: state=%0d RegWrite=%b RegDst=%b MemtoReg=%b, required 11 1 0 0", state, RegWrite, RegDst, MemtoReg);
        end
        tick();
    endtask

    task automatic test_unknown_and_illegal();
        opcode = 6'b111111;
        tick();
        checks++;
        if (state !== 4'd1 || {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite} !== 6'b0) begin
            errors++;
            $display("FAIL nop_decode: state=%0d enables=%b, required 1 000000", state,
                     {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite});
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL nop_return: state=%0d, required 0", state);
        end
        opcode = 6'b100011;
        tick(); tick(); tick(); tick();
        force dut.state_q = 4'd13;
        #1;
        checks++;
        if (state !== 4'd13 || {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                                PCSource, AluSrcA, AluSrcB, controlline} !== 17'b0) begin
            errors++;
            $display("FAIL illegal_outputs: state=%0d outputs=%b, required 13 all zero", state,
                     {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                      PCSource, AluSrcA, AluSrcB, controlline});
        end
        release dut.state_q;
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL illegal_recover: state=%0d, required 0", state);
        end
    endtask

    task automatic test_reset_midinstr();
        opcode = 6'b101011;
        tick(); tick(); tick();
        checks++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: state=%0d MemWrite=%b, required 5 1", state, MemWrite);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || IorD !== 1'b1 || state !== 4'd5) begin
            errors++;
            $display("FAIL midreset_mask: MemWrite=%b IorD=%b state=%0d, required 0 1 5", MemWrite, IorD, state);
        end
        tick();
        checks++;
        if (state !== 4'd0 || IRWrite !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: state=%0d IRWrite=%b, required 0 0", state, IRWrite);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_sw();
        test_beq_j();
        test_addi();
        test_unknown_and_illegal();
        test_reset_midinstr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
